descrambler_multi: RTL and testbench

Multi-lane Interlaken receive descrambler: per-lane meta-frame synchronisation, self-synchronous x^58+x^39+1 descrambling, scrambler-state checking and lock/loss hysteresis, with configurable thresholds and a stall-tolerant valid path. It sits between the per-lane gearbox/block-sync outputs and lane deskew/framing logic, replacing a single-lane descrambler. All lanes are independent; there is no cross-lane coupling.

---
 rtl/descrambler_pkg.sv | 51 +++++
 rtl/descrambler_lane.sv | 194 +++++++++++++++++++
 rtl/descrambler_multi.sv | 57 +++++
 tb/tb_descrambler_multi.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/descrambler_pkg.sv
// Shared definitions for the multi-lane Interlaken receive descrambler:
// lane FSM encoding, control-word codes, header codes, LFSR taps and the
// bit-serial descramble helper used by every lane.
package descrambler_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } lane_state_e;

  localparam logic [1:0] CTRL_PAYLOAD = 2'b00;
  localparam logic [1:0] CTRL_SYNC    = 2'b01;
  localparam logic [1:0] CTRL_STATE   = 2'b10;

  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_CTRL = 2'b10;

  localparam logic [63:0] STATE_WORD_MARK = 64'h2800000000000000;

  // x^58 + x^39 + 1 expressed as taps on a 58-bit shift register
  localparam int unsigned LFSR_TAP_A = 38;
  localparam int unsigned LFSR_TAP_B = 57;

  typedef struct packed {
    logic [57:0] lfsr;
    logic [63:0] data;
  } descr_t;

  // Self-synchronous descramble of one word, bit 0 first; the received
  // (scrambled) bit is what shifts into the register.
  function automatic descr_t descramble_word(input logic [57:0] lfsr_in,
                                             input logic [63:0] din);
    descr_t      res;
    logic [57:0] s;
    s        = lfsr_in;
    res.data = '0;
    for (int i = 0; i < 64; i++) begin
      res.data[i] = din[i] ^ s[LFSR_TAP_A] ^ s[LFSR_TAP_B];
      s           = {s[56:0], din[i]};
    end
    res.lfsr = s;
    return res;
  endfunction

  // 3-bit saturating increment for the good/bad/mismatch counters
  function automatic logic [2:0] inc_sat3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/descrambler_lane.sv
// One Interlaken lane: meta-frame hunt/verify/lock FSM, frame position
// counter, sync/state hysteresis counters, descrambler LFSR and the
// single-cycle output register stage.
module descrambler_lane
  import descrambler_pkg::*;
#(
  parameter int unsigned META_FRAME_LEN     = 16,
  parameter logic [63:0] SYNC_WORD          = 64'h78f678f678f678f6,
  parameter int unsigned SYNC_LOCK_CNT      = 4,
  parameter int unsigned SYNC_LOSS_CNT      = 4,
  parameter int unsigned STATE_MISMATCH_CNT = 3
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        passthrough_i,
  input  logic [63:0] data_i,
  input  logic [1:0]  header_i,
  input  logic        valid_i,
  output logic [63:0] data_o,
  output logic [1:0]  header_o,
  output logic        valid_o,
  output logic [1:0]  ctrl_o,
  output logic        locked_o,
  output logic        sync_err_o,
  output logic        state_err_o,
  output logic        hdr_err_o
);

  localparam int unsigned   CW       = $clog2(META_FRAME_LEN);
  localparam logic [CW-1:0] POS_SYNC = '0;
  localparam logic [CW-1:0] POS_STATE = CW'(1);
  localparam logic [CW-1:0] POS_LAST = CW'(META_FRAME_LEN - 1);
  localparam logic [2:0]    LOCK_THR = 3'(SYNC_LOCK_CNT);
  localparam logic [2:0]    LOSS_THR = 3'(SYNC_LOSS_CNT);
  localparam logic [2:0]    MISM_THR = 3'(STATE_MISMATCH_CNT);

  lane_state_e   state_q, state_d;
  logic [CW-1:0] ctr_q, ctr_d;
  logic [2:0]    good_q, good_d;
  logic [2:0]    bad_q, bad_d;
  logic [2:0]    mism_q, mism_d;
  logic [57:0]   lfsr_q, lfsr_d;

  logic [63:0] data_q, data_d;
  logic [1:0]  header_q;
  logic        valid_q;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        sync_err_q, sync_err_d;
  logic        state_err_q, state_err_d;
  logic        hdr_err_q;

  logic        sync_match;
  logic        state_match;
  logic [2:0]  bad_inc;
  logic [2:0]  mism_inc;
  descr_t      descr;

  // Next-state and next-output decode for one incoming word
  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q;
    good_d      = good_q;
    bad_d       = bad_q;
    mism_d      = mism_q;
    lfsr_d      = lfsr_q;
    data_d      = data_i;
    ctrl_d      = CTRL_PAYLOAD;
    sync_err_d  = 1'b0;
    state_err_d = 1'b0;
    sync_match  = (data_i == SYNC_WORD);
    state_match = (data_i[57:0] == lfsr_q);
    bad_inc     = inc_sat3(bad_q);
    mism_inc    = inc_sat3(mism_q);
    descr       = descramble_word(lfsr_q, data_i);

    if (passthrough_i) begin
      state_d = ST_HUNT;
      ctr_d   = '0;
      good_d  = '0;
      bad_d   = '0;
      mism_d  = '0;
      lfsr_d  = '1;
    end else if (valid_i) begin
      // Once framed, every valid word advances the meta-frame position
      if (state_q != ST_HUNT) begin
        ctr_d = (ctr_q == POS_LAST) ? '0 : ctr_q + 1'b1;
        if (ctr_q == POS_SYNC) begin
          ctrl_d = CTRL_SYNC;
        end else if (ctr_q == POS_STATE) begin
          ctrl_d = CTRL_STATE;
        end
      end

      case (state_q)
        ST_HUNT: begin
          if (sync_match && header_i == HDR_CTRL) begin
            state_d = ST_VERIFY;
            ctr_d   = POS_STATE;
            good_d  = 3'd1;
          end
        end
        ST_VERIFY: begin
          if (ctr_q == POS_SYNC) begin
            if (sync_match) begin
              good_d = inc_sat3(good_q);
            end else begin
              state_d = ST_HUNT;
            end
          end else if (ctr_q == POS_STATE && good_q == LOCK_THR) begin
            lfsr_d  = data_i[57:0];
            bad_d   = '0;
            mism_d  = '0;
            state_d = ST_LOCKED;
            data_d  = STATE_WORD_MARK;
          end
        end
        ST_LOCKED: begin
          if (ctr_q == POS_SYNC) begin
            if (sync_match) begin
              bad_d = '0;
            end else begin
              sync_err_d = 1'b1;
              bad_d      = bad_inc;
              if (bad_inc >= LOSS_THR) begin
                state_d = ST_HUNT;
              end
            end
          end else if (ctr_q == POS_STATE) begin
            if (state_match) begin
              mism_d = '0;
              data_d = STATE_WORD_MARK;
            end else begin
              state_err_d = 1'b1;
              mism_d      = mism_inc;
              lfsr_d      = data_i[57:0];
              if (mism_inc >= MISM_THR) begin
                state_d = ST_HUNT;
              end else begin
                data_d = STATE_WORD_MARK;
              end
            end
          end else begin
            data_d = descr.data;
            lfsr_d = descr.lfsr;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // State, counters, LFSR and aligned output registers
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= ST_HUNT;
      ctr_q       <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      mism_q      <= '0;
      lfsr_q      <= '1;
      data_q      <= '0;
      header_q    <= '0;
      valid_q     <= 1'b0;
      ctrl_q      <= CTRL_PAYLOAD;
      sync_err_q  <= 1'b0;
      state_err_q <= 1'b0;
      hdr_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      mism_q      <= mism_d;
      lfsr_q      <= lfsr_d;
      data_q      <= data_d;
      header_q    <= header_i;
      valid_q     <= valid_i;
      ctrl_q      <= ctrl_d;
      sync_err_q  <= sync_err_d;
      state_err_q <= state_err_d;
      hdr_err_q   <= valid_i && (header_i != HDR_DATA) && (header_i != HDR_CTRL);
    end
  end

  assign data_o      = data_q;
  assign header_o    = header_q;
  assign valid_o     = valid_q;
  assign ctrl_o      = ctrl_q;
  assign locked_o    = (state_q == ST_LOCKED);
  assign sync_err_o  = sync_err_q;
  assign state_err_o = state_err_q;
  assign hdr_err_o   = hdr_err_q;

endmodule

// File: rtl/descrambler_multi.sv
// Multi-lane Interlaken receive descrambler: LANES fully independent
// descrambler_lane instances sharing clock, reset and the global bypass.
module descrambler_multi
  import descrambler_pkg::*;
#(
  parameter int unsigned LANES              = 4,
  parameter int unsigned META_FRAME_LEN     = 16,
  parameter logic [63:0] SYNC_WORD          = 64'h78f678f678f678f6,
  parameter int unsigned SYNC_LOCK_CNT      = 4,
  parameter int unsigned SYNC_LOSS_CNT      = 4,
  parameter int unsigned STATE_MISMATCH_CNT = 3
) (
  input  logic                  USER_CLK,
  input  logic                  SYSTEM_RESET,
  input  logic [64*LANES-1:0]   DATA_IN,
  input  logic [2*LANES-1:0]    HEADER_IN,
  input  logic [LANES-1:0]      DATA_VALID,
  input  logic                  PASSTHROUGH,
  output logic [64*LANES-1:0]   DATA_OUT,
  output logic [2*LANES-1:0]    HEADER_OUT,
  output logic [LANES-1:0]      VALID_OUT,
  output logic [2*LANES-1:0]    CTRL_WORD,
  output logic [LANES-1:0]      LOCKED,
  output logic [LANES-1:0]      SYNC_ERR,
  output logic [LANES-1:0]      STATE_ERR,
  output logic [LANES-1:0]      HDR_ERR
);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      descrambler_lane #(
        .META_FRAME_LEN     (META_FRAME_LEN),
        .SYNC_WORD          (SYNC_WORD),
        .SYNC_LOCK_CNT      (SYNC_LOCK_CNT),
        .SYNC_LOSS_CNT      (SYNC_LOSS_CNT),
        .STATE_MISMATCH_CNT (STATE_MISMATCH_CNT)
      ) u_lane (
        .clk           (USER_CLK),
        .srst          (SYSTEM_RESET),
        .passthrough_i (PASSTHROUGH),
        .data_i        (DATA_IN[64*gi +: 64]),
        .header_i      (HEADER_IN[2*gi +: 2]),
        .valid_i       (DATA_VALID[gi]),
        .data_o        (DATA_OUT[64*gi +: 64]),
        .header_o      (HEADER_OUT[2*gi +: 2]),
        .valid_o       (VALID_OUT[gi]),
        .ctrl_o        (CTRL_WORD[2*gi +: 2]),
        .locked_o      (LOCKED[gi]),
        .sync_err_o    (SYNC_ERR[gi]),
        .state_err_o   (STATE_ERR[gi]),
        .hdr_err_o     (HDR_ERR[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_descrambler_multi.sv
// Self-checking bench for descrambler_multi: a transmitter model scrambles
// random payload into Interlaken meta-frames per lane, a behavioural receiver
// model predicts every output, and a compare process checks each cycle.
module tb_descrambler_multi;

  localparam int LANES = 4;
  localparam int MFL   = 16;
  localparam int LOCKC = 4;
  localparam int LOSSC = 4;
  localparam int MMC   = 3;
  localparam logic [63:0] SYNC = 64'h78f678f678f678f6;
  localparam logic [63:0] MARK = 64'h2800000000000000;
  localparam int M_HUNT = 0, M_VERIFY = 1, M_LOCKED = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, pass;
  logic [64*LANES-1:0] din;
  logic [2*LANES-1:0]  hin;
  logic [LANES-1:0]    vin;
  logic [64*LANES-1:0] dout;
  logic [2*LANES-1:0]  hout;
  logic [LANES-1:0]    vout;
  logic [2*LANES-1:0]  ctrl;
  logic [LANES-1:0]    locked, serr, sterr, herr;

  descrambler_multi #(
    .LANES(LANES), .META_FRAME_LEN(MFL), .SYNC_WORD(SYNC),
    .SYNC_LOCK_CNT(LOCKC), .SYNC_LOSS_CNT(LOSSC), .STATE_MISMATCH_CNT(MMC)
  ) dut (
    .USER_CLK(clk), .SYSTEM_RESET(rst), .DATA_IN(din), .HEADER_IN(hin),
    .DATA_VALID(vin), .PASSTHROUGH(pass), .DATA_OUT(dout), .HEADER_OUT(hout),
    .VALID_OUT(vout), .CTRL_WORD(ctrl), .LOCKED(locked), .SYNC_ERR(serr),
    .STATE_ERR(sterr), .HDR_ERR(herr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int lane,
                       input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lane %0d: got %h expected %h (t=%0t)", name, lane, act, exp, $time);
    end
  endtask

  // ---------------- transmitter model ----------------
  int          tx_pos[LANES];
  logic [57:0] tx_s[LANES];
  logic        tx_dirty[LANES];
  int          corrupt_sync[LANES];
  int          corrupt_state[LANES];
  int          force_gap[LANES];
  logic        gap_en, hdr_bad_en;

  // Scrambler: ciphertext bit feeds back; returns {state, ciphertext}
  function automatic logic [121:0] scramble(input logic [57:0] s_in, input logic [63:0] p);
    logic [63:0] c;
    logic [57:0] s;
    s = s_in;
    c = '0;
    for (int i = 0; i < 64; i++) begin
      c[i] = p[i] ^ s[38] ^ s[57];
      s    = {s[56:0], c[i]};
    end
    return {s, c};
  endfunction

  // Descrambler as a sliding window over the bit history: history = old
  // register contents (oldest first) followed by the 64 received bits.
  function automatic logic [121:0] descr_model(input logic [57:0] s, input logic [63:0] d);
    logic [121:0] sq;
    logic [63:0]  o;
    logic [57:0]  ns;
    for (int k = 0; k < 58; k++) sq[k] = s[57-k];
    for (int i = 0; i < 64; i++) sq[58+i] = d[i];
    for (int i = 0; i < 64; i++) o[i] = d[i] ^ sq[i] ^ sq[i+19];
    for (int j = 0; j < 58; j++) ns[j] = sq[121-j];
    return {ns, o};
  endfunction

  // ---------------- receiver model ----------------
  int          m_st[LANES], m_pos[LANES], m_good[LANES], m_bad[LANES], m_mm[LANES];
  logic [57:0] m_lfsr[LANES];

  logic        e_active = 1'b0;
  logic        e_rst;
  logic [63:0] e_data[LANES];
  logic [1:0]  e_hdr[LANES], e_ctrl[LANES];
  logic        e_valid[LANES], e_lock[LANES], e_serr[LANES], e_sterr[LANES], e_herr[LANES];
  logic        e_plain_chk[LANES];
  logic [63:0] e_plain[LANES];
  logic        e_descr[LANES];

  task automatic model_reset(input int l);
    m_st[l] = M_HUNT; m_pos[l] = 0; m_good[l] = 0; m_bad[l] = 0; m_mm[l] = 0;
    m_lfsr[l] = '1;
  endtask

  task automatic model_step(input int l, input logic r, input logic ps, input logic v,
                            input logic [63:0] d, input logic [1:0] h);
    logic [121:0] dd;
    int pos;
    e_descr[l] = 1'b0;
    e_serr[l]  = 1'b0;
    e_sterr[l] = 1'b0;
    if (r) begin
      model_reset(l);
      e_valid[l] = 0; e_data[l] = '0; e_hdr[l] = '0; e_ctrl[l] = '0;
      e_lock[l] = 0; e_herr[l] = 0;
      return;
    end
    e_valid[l] = v;
    e_hdr[l]   = h;
    e_herr[l]  = v && (h == 2'b00 || h == 2'b11);
    e_data[l]  = d;
    e_ctrl[l]  = 2'b00;
    if (ps) begin
      model_reset(l);
      e_lock[l] = 0;
      return;
    end
    if (v) begin
      pos = m_pos[l];
      if (m_st[l] != M_HUNT) begin
        e_ctrl[l] = (pos == 0) ? 2'b01 : (pos == 1) ? 2'b10 : 2'b00;
        m_pos[l]  = (pos + 1) % MFL;
      end
      if (m_st[l] == M_HUNT) begin
        if (d == SYNC && h == 2'b10) begin
          m_st[l] = M_VERIFY; m_pos[l] = 1; m_good[l] = 1;
        end
      end else if (m_st[l] == M_VERIFY) begin
        if (pos == 0) begin
          if (d == SYNC) m_good[l] = (m_good[l] < 7) ? m_good[l] + 1 : 7;
          else m_st[l] = M_HUNT;
        end else if (pos == 1 && m_good[l] == LOCKC) begin
          m_lfsr[l] = d[57:0]; m_bad[l] = 0; m_mm[l] = 0;
          m_st[l] = M_LOCKED; e_data[l] = MARK;
        end
      end else begin
        if (pos == 0) begin
          if (d == SYNC) m_bad[l] = 0;
          else begin
            e_serr[l] = 1;
            m_bad[l] = (m_bad[l] < 7) ? m_bad[l] + 1 : 7;
            if (m_bad[l] >= LOSSC) m_st[l] = M_HUNT;
          end
        end else if (pos == 1) begin
          if (d[57:0] == m_lfsr[l]) begin
            m_mm[l] = 0; e_data[l] = MARK;
          end else begin
            e_sterr[l] = 1;
            m_mm[l] = (m_mm[l] < 7) ? m_mm[l] + 1 : 7;
            m_lfsr[l] = d[57:0];
            if (m_mm[l] >= MMC) m_st[l] = M_HUNT;
            else e_data[l] = MARK;
          end
        end else begin
          dd = descr_model(m_lfsr[l], d);
          e_data[l] = dd[63:0];
          m_lfsr[l] = dd[121:64];
          e_descr[l] = 1'b1;
        end
      end
    end
    e_lock[l] = (m_st[l] == M_LOCKED);
  endtask

  // Apply one cycle of stimulus at a falling edge, update the model,
  // then advance to the next falling edge.
  task automatic drive_cycle(input logic rst_v, input logic pass_v);
    rst = rst_v; pass = pass_v; e_rst = rst_v;
    for (int l = 0; l < LANES; l++) begin
      logic v, is_pay, dirty;
      logic [63:0] w, p;
      logic [1:0] h;
      logic [121:0] sc;
      v = !rst_v; is_pay = 0; dirty = 0; p = '0;
      w = {$urandom, $urandom}; h = 2'($urandom_range(3));
      if (force_gap[l] > 0) begin v = 0; force_gap[l]--; end
      else if (gap_en && $urandom_range(7) == 0) v = 0;
      if (v) begin
        if (l == 3) begin
          h = 2'b01;
        end else if (tx_pos[l] == 0) begin
          w = SYNC; h = 2'b10;
          if (corrupt_sync[l] > 0) begin
            w = w ^ (64'h1 << $urandom_range(63)); corrupt_sync[l]--;
          end
        end else if (tx_pos[l] == 1) begin
          w = {6'b001010, tx_s[l]}; h = 2'b10;
          if (corrupt_state[l] > 0) begin
            w[0] = ~w[0]; corrupt_state[l]--; tx_dirty[l] = 1;
          end
        end else begin
          p = {$urandom, $urandom};
          sc = scramble(tx_s[l], p);
          w = sc[63:0]; tx_s[l] = sc[121:64];
          h = 2'b01; is_pay = 1; dirty = tx_dirty[l]; tx_dirty[l] = 0;
        end
        if (hdr_bad_en && tx_pos[l] >= 2 && $urandom_range(31) == 0)
          h = ($urandom_range(1) == 1) ? 2'b11 : 2'b00;
        tx_pos[l] = (tx_pos[l] + 1) % MFL;
      end
      din[64*l +: 64] = w; hin[2*l +: 2] = h; vin[l] = v;
      model_step(l, rst_v, pass_v, v, w, h);
      e_plain_chk[l] = e_descr[l] && is_pay && !dirty;
      e_plain[l] = p;
    end
    e_active = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- compare process ----------------
  int   cnt_serr[LANES], cnt_sterr[LANES], cnt_fall[LANES];
  logic prev_lock[LANES];

  initial begin
    for (int l = 0; l < LANES; l++) begin
      cnt_serr[l] = 0; cnt_sterr[l] = 0; cnt_fall[l] = 0; prev_lock[l] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      if (e_active) begin
        for (int l = 0; l < LANES; l++) begin
          check("valid_out", l, vout[l], e_valid[l]);
          check("locked", l, locked[l], e_lock[l]);
          check("sync_err", l, serr[l], e_serr[l]);
          check("state_err", l, sterr[l], e_sterr[l]);
          check("hdr_err", l, herr[l], e_herr[l]);
          if (e_valid[l] || e_rst) begin
            check("data_out", l, dout[64*l +: 64], e_data[l]);
            check("header_out", l, hout[2*l +: 2], e_hdr[l]);
            check("ctrl_word", l, ctrl[2*l +: 2], e_ctrl[l]);
          end
          if (e_plain_chk[l]) check("plaintext", l, dout[64*l +: 64], e_plain[l]);
          if (serr[l]) cnt_serr[l]++;
          if (sterr[l]) cnt_sterr[l]++;
          if (prev_lock[l] && !locked[l]) cnt_fall[l]++;
          prev_lock[l] = locked[l];
        end
      end
    end
  end

  // ---------------- stimulus and scenario checks ----------------
  initial begin
    logic [121:0] r, sc;
    logic [57:0]  s0;
    logic [63:0]  p0;
    rst = 1; pass = 0; din = '0; hin = '0; vin = '0; e_rst = 1;
    gap_en = 0; hdr_bad_en = 0;
    for (int l = 0; l < LANES; l++) begin
      tx_pos[l] = (l == 2) ? 7 : 0;
      tx_s[l] = {$urandom, $urandom};
      tx_dirty[l] = 0; corrupt_sync[l] = 0; corrupt_state[l] = 0; force_gap[l] = 0;
      model_reset(l);
    end

    // Hand-derived values that pin the reference descrambler itself
    r = descr_model('1, 64'h0);
    check("pin_ones_out", -1, r[63:0], 64'h03FFFF8000000000);
    check("pin_ones_state", -1, {6'b0, r[121:64]}, 64'h0);
    r = descr_model('0, 64'h1);
    check("pin_impulse_out", -1, r[63:0], 64'h0400008000000001);
    s0 = {$urandom, $urandom}; p0 = {$urandom, $urandom};
    sc = scramble(s0, p0);
    r  = descr_model(s0, sc[63:0]);
    check("pin_roundtrip", -1, r[63:0], p0);
    check("pin_roundtrip_state", -1, {6'b0, r[121:64]}, {6'b0, sc[121:64]});

    @(negedge clk);
    repeat (3) drive_cycle(1'b1, 1'b0);
    check("reset_data", -1, dout, '0);
    check("reset_locked", -1, {60'b0, locked}, 64'h0);
    check("reset_valid", -1, {60'b0, vout}, 64'h0);
    check("reset_ctrl", -1, {56'b0, ctrl}, 64'h0);

    // Clean gap-free start: lane 0 locks on word 49 (state word after 4th sync)
    repeat (49) drive_cycle(1'b0, 1'b0);
    check("lock_before_state", 0, locked[0], 1'b0);
    check("ctrl_4th_sync", 0, ctrl[1:0], 2'b01);
    drive_cycle(1'b0, 1'b0);
    check("lock_at_state", 0, locked[0], 1'b1);
    check("state_mark", 0, dout[63:0], MARK);
    check("ctrl_state", 0, ctrl[1:0], 2'b10);

    // Random gaps, a forced 5-cycle gap mid-frame and stray bad headers
    gap_en = 1; hdr_bad_en = 1;
    repeat (20) drive_cycle(1'b0, 1'b0);
    force_gap[1] = 5;
    repeat (80) drive_cycle(1'b0, 1'b0);
    check("lanes_locked_a", -1, {61'b0, locked[2:0]}, 64'h7);
    check("lane3_hunt", 3, locked[3], 1'b0);

    // Three bad sync words then a good one: errors but lock held
    corrupt_sync[0] = 3;
    repeat (110) drive_cycle(1'b0, 1'b0);
    check("serr_count_3", 0, cnt_serr[0], 3);
    check("lock_held_sync", 0, locked[0], 1'b1);
    check("no_fall_sync", 0, cnt_fall[0], 0);
    corrupt_sync[0] = 4;
    repeat (110) drive_cycle(1'b0, 1'b0);
    check("serr_count_7", 0, cnt_serr[0], 7);
    check("fall_sync", 0, cnt_fall[0], 1);

    // One state-word mismatch, then three in a row
    corrupt_state[1] = 1;
    repeat (60) drive_cycle(1'b0, 1'b0);
    check("sterr_count_1", 1, cnt_sterr[1], 1);
    check("lock_held_state", 1, locked[1], 1'b1);
    corrupt_state[1] = 3;
    repeat (80) drive_cycle(1'b0, 1'b0);
    check("sterr_count_4", 1, cnt_sterr[1], 4);
    check("fall_state", 1, cnt_fall[1], 1);

    repeat (200) drive_cycle(1'b0, 1'b0);
    check("relocked_b", -1, {61'b0, locked[2:0]}, 64'h7);

    // Passthrough pulse while locked
    drive_cycle(1'b0, 1'b1);
    check("pass_locked", -1, {60'b0, locked}, 64'h0);
    for (int l = 0; l < LANES; l++) begin
      check("pass_data", l, dout[64*l +: 64], din[64*l +: 64]);
      check("pass_ctrl", l, ctrl[2*l +: 2], 2'b00);
    end
    repeat (200) drive_cycle(1'b0, 1'b0);
    check("relocked_c", -1, {61'b0, locked[2:0]}, 64'h7);

    // Synchronous reset while locked
    drive_cycle(1'b1, 1'b0);
    check("rst_locked", -1, {60'b0, locked}, 64'h0);
    check("rst_data", -1, dout, '0);
    drive_cycle(1'b0, 1'b0);
    check("post_rst_locked", -1, {60'b0, locked}, 64'h0);
    for (int l = 0; l < LANES; l++)
      if (vin[l]) check("post_rst_data", l, dout[64*l +: 64], din[64*l +: 64]);
    repeat (30) drive_cycle(1'b0, 1'b0);
    check("no_early_relock", -1, {60'b0, locked}, 64'h0);
    repeat (200) drive_cycle(1'b0, 1'b0);
    check("relocked_d", -1, {61'b0, locked[2:0]}, 64'h7);
    check("lane3_hunt_end", 3, locked[3], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
